// File: rtl/mfp_srec_loader_bus_controller.sv
// AHB-Lite bus share between the CPU master and the SREC loader byte stream.
// state | meaning:  RUN = CPU owns bus;  DRAIN = wait out CPU data phase;  LOAD = replay loader bytes, CPU held
module mfp_srec_loader_bus_controller #(
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int IDLE_TIMEOUT    = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] write_address,
    input  logic [7:0]  write_byte,
    input  logic        write_enable,
    input  logic [31:0] cpu_HADDR,
    input  logic [2:0]  cpu_HBURST,
    input  logic        cpu_HMASTLOCK,
    input  logic [3:0]  cpu_HPROT,
    input  logic [2:0]  cpu_HSIZE,
    input  logic [1:0]  cpu_HTRANS,
    input  logic [31:0] cpu_HWDATA,
    input  logic        cpu_HWRITE,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic        HREADY,
    output logic        cpu_reset_n,
    output logic        loading,
    output logic        overflow
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2 + 1;
    localparam int CNT_W = $clog2(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_t;

    state_t                     state_q, state_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           idle_cnt_q, idle_cnt_d;
    logic [31:0]                ldr_wdata_q, ldr_wdata_d;
    logic                       ldr_owner_q, ldr_owner_d;
    logic                       cpu_reset_n_q, overflow_q, overflow_d;

    logic [28:0]                addr_mem [DEPTH];
    logic [7:0]                 byte_mem [DEPTH];

    logic                       fifo_empty, fifo_full, push, pop;
    logic [28:0]                head_addr;
    logic [7:0]                 head_byte;
    logic                       unused_addr_bits;

    assign unused_addr_bits = ^write_address[31:29];

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign head_addr  = addr_mem[rd_ptr_q[PW-2:0]];
    assign head_byte  = byte_mem[rd_ptr_q[PW-2:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop  = (state_q == ST_LOAD) && HREADY && !fifo_empty;
    assign push = write_enable && (!fifo_full || pop);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        overflow_d  = overflow_q || (write_enable && fifo_full && !pop);
        ldr_wdata_d = pop ? ({24'b0, head_byte} << {head_addr[1:0], 3'b000}) : ldr_wdata_q;
        ldr_owner_d = HREADY ? (state_q == ST_LOAD) : ldr_owner_q;
        idle_cnt_d  = '0;

        case (state_q)
            ST_RUN: begin
                if (write_enable) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (HREADY) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!write_enable && fifo_empty)
                    idle_cnt_d = (idle_cnt_q == IDLE_LAST) ? idle_cnt_q : idle_cnt_q + CNT_W'(1);
                // A strobe in the release cycle keeps us loading so the byte is not stranded.
                if (idle_cnt_q == IDLE_LAST && fifo_empty && HREADY && !write_enable)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            idle_cnt_q    <= '0;
            ldr_wdata_q   <= '0;
            ldr_owner_q   <= 1'b0;
            cpu_reset_n_q <= 1'b1;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            idle_cnt_q    <= idle_cnt_d;
            ldr_wdata_q   <= ldr_wdata_d;
            ldr_owner_q   <= ldr_owner_d;
            cpu_reset_n_q <= (state_d != ST_LOAD);
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr_q[PW-2:0]] <= write_address[28:0];
            byte_mem[wr_ptr_q[PW-2:0]] <= write_byte;
        end
    end

    always_comb begin
        HADDR     = cpu_HADDR;
        HBURST    = cpu_HBURST;
        HMASTLOCK = cpu_HMASTLOCK;
        HPROT     = cpu_HPROT;
        HSIZE     = cpu_HSIZE;
        HTRANS    = cpu_HTRANS;
        HWRITE    = cpu_HWRITE;
        case (state_q)
            ST_DRAIN: HTRANS = HTRANS_IDLE;
            ST_LOAD: begin
                HADDR     = {3'b000, head_addr};
                HBURST    = 3'b000;
                HMASTLOCK = 1'b0;
                HPROT     = 4'b0000;
                HSIZE     = 3'b000;
                HTRANS    = fifo_empty ? HTRANS_IDLE : HTRANS_NONSEQ;
                HWRITE    = !fifo_empty;
            end
            default: ;
        endcase
    end

    assign HWDATA      = ldr_owner_q ? ldr_wdata_q : cpu_HWDATA;
    assign cpu_reset_n = cpu_reset_n_q;
    assign loading     = (state_q != ST_RUN);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_mfp_srec_loader_bus_controller.sv
// Bench for the loader bus controller: directed scenarios plus randomized traffic
// checked against a transaction-level scoreboard of expected loader writes.
module tb_mfp_srec_loader_bus_controller;
    localparam int T     = 16;
    localparam int LOG2  = 3;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] write_address;
    logic [7:0]  write_byte;
    logic        write_enable;
    logic [31:0] cpu_HADDR;
    logic [2:0]  cpu_HBURST;
    logic        cpu_HMASTLOCK;
    logic [3:0]  cpu_HPROT;
    logic [2:0]  cpu_HSIZE;
    logic [1:0]  cpu_HTRANS;
    logic [31:0] cpu_HWDATA;
    logic        cpu_HWRITE;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    logic        cpu_reset_n;
    logic        loading;
    logic        overflow;

    always #5 clock = ~clock;

    mfp_srec_loader_bus_controller #(.FIFO_DEPTH_LOG2(LOG2), .IDLE_TIMEOUT(T)) dut (
        .clock(clock), .reset_n(reset_n),
        .write_address(write_address), .write_byte(write_byte), .write_enable(write_enable),
        .cpu_HADDR(cpu_HADDR), .cpu_HBURST(cpu_HBURST), .cpu_HMASTLOCK(cpu_HMASTLOCK),
        .cpu_HPROT(cpu_HPROT), .cpu_HSIZE(cpu_HSIZE), .cpu_HTRANS(cpu_HTRANS),
        .cpu_HWDATA(cpu_HWDATA), .cpu_HWRITE(cpu_HWRITE),
        .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HREADY(HREADY), .cpu_reset_n(cpu_reset_n), .loading(loading), .overflow(overflow)
    );

    typedef struct {
        logic [31:0] a;
        logic [7:0]  b;
    } ent_t;

    ent_t        q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_wr = 0;
    int          w0;
    logic        exp_ovf = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pend_data;
    int          burst_left = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Expected bus behaviour for one cycle; pushes/pops of the expected-write queue.
    task automatic mon();
        if (pend) begin
            chk("ld_hwdata", HWDATA, pend_data);
            pend = 1'b0;
        end
        chk("ovf", {31'b0, overflow}, {31'b0, exp_ovf});
        if (!loading) begin
            chk("run_haddr", HADDR, cpu_HADDR);
            chk("run_htrans", {30'b0, HTRANS}, {30'b0, cpu_HTRANS});
            chk("run_crst", {31'b0, cpu_reset_n}, 32'd1);
        end else if (HTRANS != 2'b00) begin
            if (q.size() == 0) begin
                chk("spurious_htrans", {30'b0, HTRANS}, 32'd0);
            end else begin
                chk("ld_haddr", HADDR, {3'b000, q[0].a[28:0]});
                chk("ld_htrans", {30'b0, HTRANS}, 32'd2);
                chk("ld_hsize", {29'b0, HSIZE}, 32'd0);
                chk("ld_hburst", {29'b0, HBURST}, 32'd0);
                chk("ld_hwrite", {31'b0, HWRITE}, 32'd1);
                if (HREADY) begin
                    pend      = 1'b1;
                    pend_data = 32'(q[0].b) << (8 * q[0].a[1:0]);
                    void'(q.pop_front());
                    n_wr++;
                end
            end
        end
        if (write_enable) begin
            if (q.size() < DEPTH) q.push_back('{a: write_address, b: write_byte});
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic sample();
        #3;
        mon();
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cpu_idle();
        cpu_HADDR     = 32'h1FC0_0000;
        cpu_HBURST    = 3'b000;
        cpu_HMASTLOCK = 1'b0;
        cpu_HPROT     = 4'b0000;
        cpu_HSIZE     = 3'b000;
        cpu_HTRANS    = 2'b00;
        cpu_HWDATA    = 32'h0;
        cpu_HWRITE    = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        sample();
        while (loading && n < 200) begin
            adv();
            sample();
            n++;
        end
        chk("idle_timeout", {31'b0, loading}, 32'd0);
        adv();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        write_enable = 1'b0; write_address = '0; write_byte = '0;
        HREADY = 1'b1;
        set_cpu_idle();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // reset values
        sample();
        chk("rst_crst", {31'b0, cpu_reset_n}, 32'd1);
        chk("rst_loading", {31'b0, loading}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_haddr", HADDR, 32'h1FC0_0000);
        adv();

        // single byte
        write_enable = 1'b1; write_address = 32'h9FC0_0002; write_byte = 8'hA5;
        sample(); adv();
        write_enable = 1'b0;
        sample();
        chk("sb_drain_loading", {31'b0, loading}, 32'd1);
        chk("sb_drain_htrans", {30'b0, HTRANS}, 32'd0);
        chk("sb_drain_crst", {31'b0, cpu_reset_n}, 32'd1);
        adv();
        sample();
        chk("sb_haddr", HADDR, 32'h1FC0_0002);
        chk("sb_hsize", {29'b0, HSIZE}, 32'd0);
        chk("sb_htrans", {30'b0, HTRANS}, 32'd2);
        chk("sb_hwrite", {31'b0, HWRITE}, 32'd1);
        chk("sb_crst_low", {31'b0, cpu_reset_n}, 32'd0);
        adv();
        sample();
        chk("sb_hwdata", HWDATA, 32'h00A5_0000);
        adv();
        for (int k = 4; k < T + 2; k++) begin
            sample(); adv();
        end
        sample();
        chk("sb_pre_release", {31'b0, loading}, 32'd1);
        adv();
        sample();
        chk("sb_release_loading", {31'b0, loading}, 32'd0);
        chk("sb_release_crst", {31'b0, cpu_reset_n}, 32'd1);
        adv();

        // drain with wait states
        cpu_HTRANS = 2'b10; cpu_HWRITE = 1'b1; cpu_HADDR = 32'h0000_1000; cpu_HSIZE = 3'b010;
        write_enable = 1'b1; write_address = 32'h0000_0100; write_byte = 8'h5A; HREADY = 1'b1;
        sample(); adv();
        write_enable = 1'b0; cpu_HWDATA = 32'hDEAD_BEEF; HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("dr_htrans", {30'b0, HTRANS}, 32'd0);
            chk("dr_hwdata", HWDATA, 32'hDEAD_BEEF);
            chk("dr_crst", {31'b0, cpu_reset_n}, 32'd1);
            adv();
        end
        HREADY = 1'b1;
        sample();
        chk("dr_ready_idle", {30'b0, HTRANS}, 32'd0);
        adv();
        sample();
        chk("dr_first_nonseq", {30'b0, HTRANS}, 32'd2);
        chk("dr_first_haddr", HADDR, 32'h0000_0100);
        adv();
        set_cpu_idle();
        wait_idle();

        // streaming
        w0 = n_wr;
        for (int i = 0; i < 8; i++) begin
            write_enable = 1'b1; write_address = 32'(i); write_byte = 8'(8'h10 + i);
            sample(); adv();
        end
        write_enable = 1'b0;
        wait_idle();
        chk("st_count", 32'(n_wr - w0), 32'd8);
        chk("st_ovf", {31'b0, overflow}, 32'd0);

        // overflow
        w0 = n_wr;
        for (int i = 0; i < 10; i++) begin
            write_enable = 1'b1; write_address = 32'h0000_2000 + 32'(i); write_byte = 8'(8'h80 + i);
            HREADY = (i < 2);
            sample();
            if (i == 8) chk("ov_before", {31'b0, overflow}, 32'd0);
            if (i == 9) chk("ov_rise", {31'b0, overflow}, 32'd1);
            adv();
        end
        write_enable = 1'b0; HREADY = 1'b1;
        wait_idle();
        chk("ov_count", 32'(n_wr - w0), 32'd8);
        chk("ov_sticky", {31'b0, overflow}, 32'd1);

        // reset mid-LOAD
        w0 = n_wr;
        for (int i = 0; i < 4; i++) begin
            write_enable = 1'b1; write_address = 32'h0000_3000 + 32'(i); write_byte = 8'(i);
            HREADY = (i < 2);
            sample(); adv();
        end
        write_enable = 1'b0; HREADY = 1'b0;
        sample();
        chk("rm_loading_pre", {31'b0, loading}, 32'd1);
        #1;
        reset_n = 1'b0;
        q.delete(); exp_ovf = 1'b0; pend = 1'b0;
        #1;
        chk("rm_loading", {31'b0, loading}, 32'd0);
        chk("rm_crst", {31'b0, cpu_reset_n}, 32'd1);
        chk("rm_ovf", {31'b0, overflow}, 32'd0);
        chk("rm_haddr", HADDR, cpu_HADDR);
        chk("rm_htrans", {30'b0, HTRANS}, {30'b0, cpu_HTRANS});
        adv();
        sample(); adv();
        reset_n = 1'b1; HREADY = 1'b1;
        for (int i = 0; i < 25; i++) begin
            sample(); adv();
        end
        chk("rm_no_writes", 32'(n_wr - w0), 32'd0);
        chk("rm_loading_after", {31'b0, loading}, 32'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cpu_HADDR     = $urandom;
            cpu_HBURST    = 3'($urandom_range(0, 7));
            cpu_HMASTLOCK = 1'($urandom_range(0, 1));
            cpu_HPROT     = 4'($urandom_range(0, 15));
            cpu_HSIZE     = 3'($urandom_range(0, 2));
            cpu_HTRANS    = 2'($urandom_range(0, 3));
            cpu_HWDATA    = $urandom;
            cpu_HWRITE    = 1'($urandom_range(0, 1));
            HREADY        = ($urandom_range(0, 3) != 0);
            if (burst_left == 0 && $urandom_range(0, 39) == 0) burst_left = $urandom_range(1, 20);
            if (burst_left > 0) begin
                burst_left--;
                write_enable = 1'($urandom_range(0, 1));
            end else begin
                write_enable = 1'b0;
            end
            write_address = $urandom;
            write_byte    = 8'($urandom_range(0, 255));
            sample(); adv();
        end
        write_enable = 1'b0; HREADY = 1'b1;
        set_cpu_idle();
        wait_idle();
        chk("rnd_all_written", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
